ota_bitstream_decimator: RTL and testbench

//  Receive end of the digital OTA comparator: samples its 1-bit output stream, counts ones over a

---
 rtl/ota_dec_pkg.sv | 25 ++
 rtl/ota_bitstream_decimator_if.sv | 12 +
 rtl/ota_sync2.sv | 23 ++
 rtl/ota_bitstream_decimator.sv | 139 +++++++++++++
 tb/tb_ota_bitstream_decimator.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/ota_dec_pkg.sv
// Shared types and helpers for the OTA bitstream decimator.
// The optional input deglitch stage is enabled by defining OTA_DEC_DEGLITCH_EN.
package ota_dec_pkg;

  // Decimator control states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2
  } state_t;

  // Settle counter width covers SETTLE_CYC values 0..255
  localparam int SETTLE_CNT_W = 8;

  // Number of samples in one window
  function automatic int win_len(input int log2);
    return 1 << log2;
  endfunction

  // Code must hold 0..2**log2 inclusive, hence one extra bit
  function automatic int code_width(input int log2);
    return log2 + 1;
  endfunction

endpackage

// File: rtl/ota_bitstream_decimator_if.sv
// Valid/ready result port of the OTA bitstream decimator.
// master = decimator (produces code), slave = readout logic (consumes code).
interface ota_bitstream_decimator_if #(
  parameter int CODE_W = 6
);
  logic [CODE_W-1:0] code;
  logic              code_valid;
  logic              code_ready;

  modport master (output code, output code_valid, input code_ready);
  modport slave  (input code, input code_valid, output code_ready);
endinterface

// File: rtl/ota_sync2.sv
// Two-flop synchronizer for one asynchronous input, reset to 0.
module ota_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic r_meta;
  logic r_sync;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;
endmodule

// File: rtl/ota_bitstream_decimator.sv
// Counts comparator ones over a 2**WIN_LOG2-sample window and hands the duty-cycle
// code out through a valid/ready port. Define OTA_DEC_DEGLITCH_EN to add a 3-tap
// majority filter behind the synchronizer (one extra cycle of input latency).
module ota_bitstream_decimator
  import ota_dec_pkg::*;
#(
  parameter int WIN_LOG2   = 5,
  parameter int SETTLE_CYC = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      cmp_in,
  ota_bitstream_decimator_if.master code_if,
  output logic                      overrun,
  input  logic                      ovr_clr,
  output logic                      busy
);
  localparam int CODE_W = code_width(WIN_LOG2);
  localparam logic [WIN_LOG2-1:0]     WIN_LAST    = '1;
  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST =
    SETTLE_CNT_W'((SETTLE_CYC == 0) ? 0 : SETTLE_CYC - 1);

  state_t                  r_state;
  logic [SETTLE_CNT_W-1:0] r_settle_cnt;
  logic [WIN_LOG2-1:0]     r_win_cnt;
  logic [CODE_W-1:0]       r_acc;
  logic [CODE_W-1:0]       r_code;
  logic                    r_code_valid;
  logic                    r_overrun;

  logic w_sync;
  logic w_sample;
  logic w_last;
  logic w_done;
  logic w_take;

  ota_sync2 u_sync_cmp (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (cmp_in),
    .q    (w_sync)
  );

`ifdef OTA_DEC_DEGLITCH_EN
  logic [1:0] r_taps;
  logic       r_maj;

  // Majority of the current and two previous synchronized samples, registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_taps <= 2'b00;
      r_maj  <= 1'b0;
    end else begin
      r_taps <= {r_taps[0], w_sync};
      r_maj  <= (w_sync & r_taps[0]) | (w_sync & r_taps[1]) | (r_taps[0] & r_taps[1]);
    end
  end

  assign w_sample = r_maj;
`else
  assign w_sample = w_sync;
`endif

  assign w_last = (r_win_cnt == WIN_LAST);
  assign w_done = (r_state == RUN) && en && w_last;
  assign w_take = r_code_valid && code_if.code_ready;

  // Control FSM with settle counter, window counter and ones accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_settle_cnt <= '0;
      r_win_cnt    <= '0;
      r_acc        <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_settle_cnt <= '0;
          r_win_cnt    <= '0;
          r_acc        <= '0;
          if (en) begin
            r_state <= (SETTLE_CYC == 0) ? RUN : SETTLE;
          end
        end
        SETTLE: begin
          if (!en) begin
            r_state <= IDLE;
          end else if (r_settle_cnt == SETTLE_LAST) begin
            r_state <= RUN;
          end else begin
            r_settle_cnt <= r_settle_cnt + 1'b1;
          end
        end
        RUN: begin
          if (!en) begin
            // Abort: partial window is thrown away
            r_state   <= IDLE;
            r_win_cnt <= '0;
            r_acc     <= '0;
          end else if (w_last) begin
            r_win_cnt <= '0;
            r_acc     <= '0;
          end else begin
            r_win_cnt <= r_win_cnt + 1'b1;
            r_acc     <= r_acc + CODE_W'(w_sample);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Result register, valid flag and sticky overrun (set beats clear)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_code       <= '0;
      r_code_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_done) begin
        r_code       <= r_acc + CODE_W'(w_sample);
        r_code_valid <= 1'b1;
      end else if (w_take) begin
        r_code_valid <= 1'b0;
      end
      if (w_done && r_code_valid && !code_if.code_ready) begin
        r_overrun <= 1'b1;
      end else if (ovr_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign code_if.code       = r_code;
  assign code_if.code_valid = r_code_valid;
  assign overrun            = r_overrun;
  assign busy               = (r_state != IDLE);
endmodule

// File: tb/tb_ota_bitstream_decimator.sv
// Randomized scoreboard bench for ota_bitstream_decimator.
// Honors OTA_DEC_DEGLITCH_EN the same way the design does.
module tb_ota_bitstream_decimator;
  import ota_dec_pkg::*;

  localparam int WIN_LOG2   = 5;
  localparam int SETTLE_CYC = 4;
  localparam int WIN        = 1 << WIN_LOG2;
  localparam int CODE_W     = WIN_LOG2 + 1;
  localparam int HIST_N     = 8192;

  logic clk     = 1'b0;
  logic rst_n   = 1'b1;
  logic en      = 1'b0;
  logic cmp_in  = 1'b0;
  logic ovr_clr = 1'b0;
  logic overrun;
  logic busy;

  ota_bitstream_decimator_if #(.CODE_W(CODE_W)) dec_if ();

  ota_bitstream_decimator #(
    .WIN_LOG2  (WIN_LOG2),
    .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .cmp_in (cmp_in),
    .code_if(dec_if),
    .overrun(overrun),
    .ovr_clr(ovr_clr),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  // Reference model state
  int  tests = 0;
  int  fails = 0;
  int  drops = 0;
  int  n_edge = 0;
  bit  hist[HIST_N];
  bit  m_active = 0;
  bit  m_ovr = 0;
  int  run_start = 0;
  int  m_cnt = 0;
  int  m_acc = 0;
  int  exp_q[$];
  int  mon_exp;
  int  snap_code;
  int  snap_valid;

  function automatic bit h(input int i);
    if (i < 0 || i >= HIST_N) return 1'b0;
    return hist[i];
  endfunction

  // Value the window accumulator sees at edge n, derived from the raw input history
  function automatic bit sample_at(input int n);
`ifdef OTA_DEC_DEGLITCH_EN
    bit a, b, c;
    a = h(n - 3);
    b = h(n - 4);
    c = h(n - 5);
    return (a & b) | (a & c) | (b & c);
`else
    return h(n - 2);
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, n_edge);
    end
  endtask

  // One clock cycle of stimulus plus model update and per-cycle flag checks
  task automatic step(input bit e, input bit c, input bit r, input bit clr);
    bit pushed;
    bit had_pending;
    en                = e;
    cmp_in            = c;
    dec_if.code_ready = r;
    ovr_clr           = clr;
    @(posedge clk);
    n_edge++;
    pushed      = 1'b0;
    had_pending = (exp_q.size() > 0);
    if (n_edge < HIST_N) hist[n_edge] = rst_n ? c : 1'b0;
    if (!rst_n) begin
      m_active = 0;
      m_ovr    = 0;
      exp_q.delete();
    end else if (!e) begin
      m_active = 0;
    end else if (!m_active) begin
      m_active  = 1;
      run_start = n_edge + 1 + SETTLE_CYC;
      m_cnt     = 0;
      m_acc     = 0;
    end else if (n_edge >= run_start) begin
      m_acc += int'(sample_at(n_edge));
      m_cnt++;
      if (m_cnt == WIN) begin
        exp_q.push_back(m_acc);
        pushed = 1'b1;
        m_cnt  = 0;
        m_acc  = 0;
      end
    end
    if (rst_n) begin
      if (pushed && had_pending) m_ovr = 1;
      else if (clr)              m_ovr = 0;
    end
    #1;
    check("overrun", int'(overrun), int'(m_ovr));
    check("code_valid", int'(dec_if.code_valid), (exp_q.size() > 0) ? 1 : 0);
    check("busy", int'(busy), int'(m_active));
  endtask

  // Monitor: on each handshake the consumer must see the newest completed window
  always @(negedge clk) begin
    if (rst_n && dec_if.code_valid && dec_if.code_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL handshake: code %0d presented, no window expected", dec_if.code);
      end else begin
        mon_exp = exp_q[$];
        drops += exp_q.size() - 1;
        exp_q.delete();
        if (int'(dec_if.code) != mon_exp) begin
          fails++;
          $display("FAIL code: got %0d, expected %0d", dec_if.code, mon_exp);
        end else begin
          $display("[TB] window code=%0d expected=%0d", dec_if.code, mon_exp);
        end
      end
    end
  end

  initial begin
    dec_if.code_ready = 1'b0;
    // Power-on reset
    #1 rst_n = 1'b0;
    #1;
    check("rst_code", int'(dec_if.code), 0);
    check("rst_valid", int'(dec_if.code_valid), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_busy", int'(busy), 0);
    repeat (3) step(0, 0, 0, 0);
    rst_n = 1'b1;
    repeat (3) step(0, 0, 0, 0);

    // 1: constant ones -> full-scale code every window
    repeat (SETTLE_CYC + 1 + 3 * WIN + 2) step(1, 1, 1, 0);

    // 2: alternating input (110 pattern when deglitched)
    repeat (2) step(0, 0, 1, 0);
    for (int i = 0; i < SETTLE_CYC + 1 + 3 * WIN + 2; i++) begin
`ifdef OTA_DEC_DEGLITCH_EN
      step(1, (i % 3) != 2, 1, 0);
`else
      step(1, i[0], 1, 0);
`endif
    end

    // 3a: consumer stalled across two windows -> overrun, newest code delivered
    repeat (2) step(0, 0, 1, 0);
    drops = 0;
    repeat (SETTLE_CYC + 1 + 2 * WIN + 3) step(1, 1'($urandom_range(0, 1)), 0, 0);
    check("ovr_set", int'(overrun), 1);
    repeat (3) step(1, 1'($urandom_range(0, 1)), 1, 0);
    check("ovr_drops", drops, 1);
    step(1, 1'($urandom_range(0, 1)), 1, 1);
    check("ovr_clr", int'(overrun), 0);
    // 3b: clear held during a new overrun event -> set wins for that cycle
    drops = 0;
    repeat (2 * WIN + 4) step(1, 1'($urandom_range(0, 1)), 0, 1);
    repeat (3) step(1, 1'($urandom_range(0, 1)), 1, 0);
    check("ovr_drops2", drops, 1);

    // 4: enable drops mid-window, pending result left untouched
    repeat (2) step(0, 0, 1, 0);
    repeat (SETTLE_CYC + 1 + WIN + 10) step(1, 1'($urandom_range(0, 1)), 0, 0);
    snap_code  = int'(dec_if.code);
    snap_valid = int'(dec_if.code_valid);
    step(0, 1'($urandom_range(0, 1)), 0, 0);
    check("abort_valid", int'(dec_if.code_valid), snap_valid);
    check("abort_code", int'(dec_if.code), snap_code);
    check("abort_busy", int'(busy), 0);
    repeat (2) step(0, 0, 1, 0);
    repeat (SETTLE_CYC + 1 + WIN + 2) step(1, 1'($urandom_range(0, 1)), 1, 0);

    // 5: asynchronous reset in the middle of a window
    repeat (SETTLE_CYC + 1 + 20) step(1, 1'($urandom_range(0, 1)), 1, 0);
    #1 rst_n = 1'b0;
    #1;
    check("arst_code", int'(dec_if.code), 0);
    check("arst_valid", int'(dec_if.code_valid), 0);
    check("arst_overrun", int'(overrun), 0);
    check("arst_busy", int'(busy), 0);
    m_active = 0;
    m_ovr    = 0;
    exp_q.delete();
    repeat (2) step(1, 1'($urandom_range(0, 1)), 1, 0);
    rst_n = 1'b1;
    repeat (SETTLE_CYC + 1 + WIN + 2) step(1, 1, 1, 0);

    // 6: random bitstream, consumer always ready -> every window exactly once
    drops = 0;
    repeat (SETTLE_CYC + 1 + 20 * WIN + 2) step(1, 1'($urandom_range(0, 1)), 1, 0);
    check("rand_drops", drops, 0);
    check("rand_overrun", int'(overrun), 0);

    repeat (3) step(0, 0, 1, 0);
    check("pending", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
